// File: rtl/imm_gen_pkg.sv
// Shared format encodings and FSM state type for the registered immediate generator.
package imm_gen_pkg;

  localparam logic [1:0] FMT_SEXT   = 2'b00;
  localparam logic [1:0] FMT_SHL1   = 2'b01;
  localparam logic [1:0] FMT_HIGH   = 2'b10;
  localparam logic [1:0] FMT_PREFIX = 2'b11;

  typedef enum logic {
    IDLE     = 1'b0,
    PREFIXED = 1'b1
  } state_t;

endpackage

// File: rtl/imm_format_comb.sv
// Combinational immediate formatter: next output value and next prefix value
// from the instruction field, format select, prefix register and FSM state.
module imm_format_comb
  import imm_gen_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned FIELD_W = 8
) (
  input  logic [FIELD_W-1:0] f,
  input  logic [1:0]         fmt,
  input  logic [DATA_W-1:0]  prefix,
  input  state_t             state,
  output logic [DATA_W-1:0]  out_nxt_c,
  output logic [DATA_W-1:0]  prefix_nxt_c
);

  localparam int unsigned EXT_W = DATA_W - FIELD_W;

  logic [DATA_W-1:0] sext_c;
  logic [DATA_W-1:0] high_c;
  logic [DATA_W-1:0] cat_c;
  logic [DATA_W-1:0] base_c;

  // With a pending prefix the field is appended unsigned; bits shifted past DATA_W are lost.
  always_comb begin
    sext_c       = {{EXT_W{f[FIELD_W-1]}}, f};
    high_c       = {f, {EXT_W{1'b0}}};
    cat_c        = DATA_W'({prefix, f});
    base_c       = (state == PREFIXED) ? cat_c : sext_c;
    out_nxt_c    = base_c;
    prefix_nxt_c = (state == PREFIXED) ? cat_c : {{EXT_W{1'b0}}, f};
    case (fmt)
      FMT_SHL1: out_nxt_c = {base_c[DATA_W-2:0], 1'b0};
      FMT_HIGH: if (state == IDLE) out_nxt_c = high_c;
      default:  ;
    endcase
  end

endmodule

// File: rtl/imm_gen_seq.sv
// Registered immediate generator with prefix accumulation and valid/ready on both sides.
// Define IMM_GEN_STATS_EN to add the imm_count emitted-immediate counter.
module imm_gen_seq
  import imm_gen_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned INST_W  = 16,
  parameter int unsigned FIELD_W = 8
`ifdef IMM_GEN_STATS_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [INST_W-1:0] inst,
  input  logic [1:0]        fmt,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              prefix_pending
`ifdef IMM_GEN_STATS_EN
  , output logic [CNT_W-1:0] imm_count
`endif
);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] prefix;
  logic [DATA_W-1:0] prefix_nxt;
  logic [DATA_W-1:0] out_nxt;
  logic              out_valid_nxt;
  logic [DATA_W-1:0] fmt_out_c;
  logic [DATA_W-1:0] fmt_prefix_c;
  logic              accept_c;
  logic              emit_c;

  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready && !flush;
  assign emit_c   = accept_c && (fmt != FMT_PREFIX);

  // Only the top FIELD_W instruction bits carry the immediate field.
  if (INST_W > FIELD_W) begin : g_low_bits
    logic unused_inst_c;
    assign unused_inst_c = ^inst[INST_W-FIELD_W-1:0];
  end

  imm_format_comb #(
    .DATA_W  (DATA_W),
    .FIELD_W (FIELD_W)
  ) u_format (
    .f            (inst[INST_W-1 -: FIELD_W]),
    .fmt          (fmt),
    .prefix       (prefix),
    .state        (state),
    .out_nxt_c    (fmt_out_c),
    .prefix_nxt_c (fmt_prefix_c)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      prefix         <= '0;
      out            <= '0;
      out_valid      <= 1'b0;
      prefix_pending <= 1'b0;
    end else begin
      state          <= state_nxt;
      prefix         <= prefix_nxt;
      out            <= out_nxt;
      out_valid      <= out_valid_nxt;
      prefix_pending <= (state_nxt == PREFIXED);
    end
  end

  // Flush wins over both accept and retire; a retire without a new emit drops out_valid.
  always_comb begin
    state_nxt     = state;
    prefix_nxt    = prefix;
    out_nxt       = out;
    out_valid_nxt = out_valid;
    if (flush) begin
      state_nxt     = IDLE;
      prefix_nxt    = '0;
      out_valid_nxt = 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid_nxt = 1'b0;
      if (accept_c) begin
        if (fmt == FMT_PREFIX) begin
          state_nxt  = PREFIXED;
          prefix_nxt = fmt_prefix_c;
        end else begin
          state_nxt     = IDLE;
          prefix_nxt    = '0;
          out_nxt       = fmt_out_c;
          out_valid_nxt = 1'b1;
        end
      end
    end
  end

`ifdef IMM_GEN_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) imm_count <= '0;
    else if (emit_c) imm_count <= imm_count + CNT_W'(1);
  end
`else
  logic unused_emit_c;
  assign unused_emit_c = emit_c;
`endif

endmodule

// File: tb/tb_imm_gen_seq.sv
// Scoreboard bench for imm_gen_seq: expected immediates are queued at drive time
// and compared when the DUT retires them.
module tb_imm_gen_seq;
  import imm_gen_pkg::*;

  logic        clock;
  logic        reset;
  logic [15:0] inst;
  logic [1:0]  fmt;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        prefix_pending;
`ifdef IMM_GEN_STATS_EN
  logic [15:0] imm_count;
  int          exp_cnt = 0;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];

  imm_gen_seq dut (
    .clock          (clock),
    .reset          (reset),
    .inst           (inst),
    .fmt            (fmt),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .flush          (flush),
    .out            (out),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .prefix_pending (prefix_pending)
`ifdef IMM_GEN_STATS_EN
    , .imm_count    (imm_count)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] e);
    exp_q.push_back(e);
`ifdef IMM_GEN_STATS_EN
    exp_cnt++;
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One-cycle transfer; caller guarantees in_ready.
  task automatic send(input logic [1:0] f, input logic [15:0] i, input logic [15:0] e);
    in_valid = 1'b1;
    fmt      = f;
    inst     = i;
    if (f != FMT_PREFIX) push(e);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    if (f != FMT_PREFIX) begin
      check("lat_valid", 16'(out_valid), 16'd1);
      check("lat_out", out, e);
    end else begin
      check("pfx_pending", 16'(prefix_pending), 16'd1);
    end
  endtask

  // Output monitor: an item retires on the next edge when valid && ready and no flush.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready && !flush) begin
      check("out_pending", 16'(exp_q.size() != 0), 16'd1);
      if (exp_q.size() != 0) check("out_value", out, exp_q.pop_front());
    end
  end

  initial begin
    reset     = 1'b1;
    inst      = '0;
    fmt       = FMT_SEXT;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_out", out, 16'h0000);
    check("rst_valid", 16'(out_valid), 16'd0);
    check("rst_pending", 16'(prefix_pending), 16'd0);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    reset = 1'b0;
    idle(1);

    // Single-instruction formats
    send(FMT_SEXT, 16'h25F8, 16'h0025);
    send(FMT_SEXT, 16'hF359, 16'hFFF3);
    send(FMT_SHL1, 16'h9696, 16'hFF2C);
    send(FMT_HIGH, 16'h4B65, 16'h4B00);

    // Prefix chains
    send(FMT_PREFIX, 16'h12AA, 16'h0000);
    check("pfx_no_out", 16'(out_valid), 16'd0);
    send(FMT_SEXT, 16'h34BB, 16'h1234);
    check("pfx_cleared", 16'(prefix_pending), 16'd0);
    send(FMT_PREFIX, 16'h1200, 16'h0000);
    send(FMT_PREFIX, 16'h3400, 16'h0000);
    send(FMT_SEXT, 16'h5600, 16'h3456);
    send(FMT_PREFIX, 16'h0100, 16'h0000);
    send(FMT_SHL1, 16'h8000, 16'h0300);
    send(FMT_PREFIX, 16'hFF00, 16'h0000);
    send(FMT_HIGH, 16'h0100, 16'hFF01);
    send(FMT_PREFIX, 16'h0000, 16'h0000);
    send(FMT_SEXT, 16'h8000, 16'h0080);
    idle(1);

    // Backpressure: output held, input refused, then retire and accept on the same edge
    out_ready = 1'b0;
    send(FMT_SEXT, 16'h8000, 16'hFF80);
    in_valid = 1'b1;
    fmt      = FMT_SHL1;
    inst     = 16'h0100;
    for (int c = 0; c < 3; c++) begin
      check("bp_in_ready", 16'(in_ready), 16'd0);
      check("bp_out_hold", out, 16'hFF80);
      check("bp_valid_hold", 16'(out_valid), 16'd1);
      idle(1);
    end
    out_ready = 1'b1;
    push(16'h0002);
    idle(1);
    in_valid = 1'b0;
    check("bp_release_out", out, 16'h0002);
    check("bp_release_valid", 16'(out_valid), 16'd1);
    idle(1);

    // Flush discards the pending prefix, then drops a simultaneous input
    send(FMT_PREFIX, 16'h7F00, 16'h0000);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    check("flush_pending", 16'(prefix_pending), 16'd0);
    send(FMT_SEXT, 16'h8000, 16'hFF80);
    idle(1);
    flush    = 1'b1;
    in_valid = 1'b1;
    fmt      = FMT_SEXT;
    inst     = 16'h1100;
    idle(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_drop_valid", 16'(out_valid), 16'd0);
    check("flush_out_hold", out, 16'hFF80);
    idle(1);

`ifdef IMM_GEN_STATS_EN
    check("imm_count", imm_count, 16'(exp_cnt));
`endif

    // Asynchronous reset with a held output
    out_ready = 1'b0;
    send(FMT_SEXT, 16'h5A00, 16'h005A);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 16'(out_valid), 16'd0);
    check("arst_out", out, 16'h0000);
`ifdef IMM_GEN_STATS_EN
    check("arst_count", imm_count, 16'd0);
    exp_cnt = 0;
`endif
    exp_q.delete();
    reset     = 1'b0;
    out_ready = 1'b1;
    idle(1);

    // Asynchronous reset mid prefix chain; the prefix must not survive
    send(FMT_PREFIX, 16'h1200, 16'h0000);
    send(FMT_PREFIX, 16'h3400, 16'h0000);
    #2 reset = 1'b1;
    #1;
    check("arst_pending", 16'(prefix_pending), 16'd0);
    reset = 1'b0;
    idle(1);
    send(FMT_SEXT, 16'h5600, 16'h0056);
    idle(3);

    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
